// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Dynamic branch predictor for the pipelined RISC-V core. The branch target
// buffer is direct-mapped, with one entry per set. Each entry holds a valid
// bit, a tag, a target and a saturating counter.
//
// Lookup is combinational on the fetch PC. Updates are registered and come
// from the branch-resolve stage. The block also raises the mispredict/flush
// request, supplies the redirect PC and keeps saturating performance
// counters.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable            global run enable; gates every state update
//   pc_if             fetch-stage PC
//   pred_taken        prediction for pc_if
//   pred_target       next fetch PC
//   upd_valid         a resolved branch/jump is presented this cycle
//   upd_pc            PC of the resolved instruction
//   upd_taken         actual outcome
//   upd_target        actual taken target
//   upd_pred_taken    prediction made at fetch (piped down)
//   upd_pred_target   predicted next PC carried down the pipe
//   mispredict        flush request
//   redirect_pc       correct next PC when mispredict=1
//   stat_branches     resolved-branch count (saturating)
//   stat_mispredicts  mispredict count (saturating)
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int ADDR_W  = 64,
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 8,
   parameter int CNT_W   = 2,
   parameter int STAT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [ADDR_W-1:0] pc_if,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   // Allocation starts weakly taken: only the counter MSB is set.
   localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   logic                valid_r  [ENTRIES];
   logic [TAG_W-1:0]    tag_r    [ENTRIES];
   logic [ADDR_W-1:0]   target_r [ENTRIES];
   logic [CNT_W-1:0]    cnt_r    [ENTRIES];
   logic [STAT_W-1:0]   stat_br_r;
   logic [STAT_W-1:0]   stat_mp_r;

   logic [IDX_W-1:0]    lk_idx_s;
   logic [TAG_W-1:0]    lk_tag_s;
   logic                lk_hit_s;
   logic [IDX_W-1:0]    up_idx_s;
   logic [TAG_W-1:0]    up_tag_s;
   logic                up_hit_s;
   logic                mispredict_s;

   // Split both PCs into index and tag. Bits [1:0] never take part.
   assign lk_idx_s = pc_if[IDX_W+1:2];
   assign lk_tag_s = pc_if[IDX_W+TAG_W+1:IDX_W+2];
   assign up_idx_s = upd_pc[IDX_W+1:2];
   assign up_tag_s = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

   // Fetch lookup. It reads the pre-update array, so a same-cycle update
   // becomes visible only on the following cycle.
   always_comb begin
      lk_hit_s = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
      if (lk_hit_s && cnt_r[lk_idx_s][CNT_W-1]) begin
         pred_taken  = 1'b1;
         pred_target = target_r[lk_idx_s];
      end else begin
         pred_taken  = 1'b0;
         pred_target = pc_if + ADDR_W'(4);
      end
   end

   // Mispredict detection and redirect PC. These do not depend on enable.
   always_comb begin
      up_hit_s     = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
      mispredict_s = upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_target)));
      if (upd_taken) begin
         redirect_pc = upd_target;
      end else begin
         redirect_pc = upd_pc + ADDR_W'(4);
      end
   end

   assign mispredict       = mispredict_s;
   assign stat_branches    = stat_br_r;
   assign stat_mispredicts = stat_mp_r;

   // BTB state: clear on reset, otherwise train on enabled resolve updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= {TAG_W{1'b0}};
            target_r[i] <= {ADDR_W{1'b0}};
            cnt_r[i]    <= CNT_ZERO;
         end
      end else if (enable && upd_valid) begin
         if (up_hit_s) begin
            if (upd_taken) begin
               target_r[up_idx_s] <= upd_target;
               if (cnt_r[up_idx_s] != CNT_MAX) begin
                  cnt_r[up_idx_s] <= cnt_r[up_idx_s] + CNT_W'(1);
               end
            end else if (cnt_r[up_idx_s] != CNT_ZERO) begin
               cnt_r[up_idx_s] <= cnt_r[up_idx_s] - CNT_W'(1);
            end
         end else if (upd_taken) begin
            // A taken miss allocates the entry or replaces the alias.
            valid_r[up_idx_s]  <= 1'b1;
            tag_r[up_idx_s]    <= up_tag_s;
            target_r[up_idx_s] <= upd_target;
            cnt_r[up_idx_s]    <= CNT_WEAK;
         end
      end
   end

   // Saturating performance counters. They never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_br_r <= {STAT_W{1'b0}};
         stat_mp_r <= {STAT_W{1'b0}};
      end else if (enable) begin
         if (upd_valid && (stat_br_r != STAT_MAX)) begin
            stat_br_r <= stat_br_r + STAT_W'(1);
         end
         if (mispredict_s && (stat_mp_r != STAT_MAX)) begin
            stat_mp_r <= stat_mp_r + STAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam int ADDR_W = 64;
   localparam int STAT_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [ADDR_W-1:0] pc_if;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic              upd_taken;
   logic [ADDR_W-1:0] upd_target;
   logic              upd_pred_taken;
   logic [ADDR_W-1:0] upd_pred_target;
   logic              mispredict;
   logic [ADDR_W-1:0] redirect_pc;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispredicts;

   int total = 0;
   int bad   = 0;

   branch_predictor #(
      .ADDR_W(ADDR_W), .ENTRIES(16), .TAG_W(8), .CNT_W(2), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .pc_if(pc_if),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .stat_branches(stat_branches),
      .stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are changed 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                      input logic ptk, input logic [63:0] ptgt);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      upd_pred_taken = ptk; upd_pred_target = ptgt;
   endtask

   task automatic look(input logic [63:0] pc, input logic exp_tk, input logic [63:0] exp_tgt,
                       input string tag);
      pc_if = pc;
      #1;
      chk({tag, "_taken"}, {63'd0, pred_taken}, {63'd0, exp_tk});
      chk({tag, "_target"}, pred_target, exp_tgt);
   endtask

   task automatic stats(input logic [3:0] br, input logic [3:0] mp, input string tag);
      chk({tag, "_br"}, {60'd0, stat_branches}, {60'd0, br});
      chk({tag, "_mp"}, {60'd0, stat_mispredicts}, {60'd0, mp});
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; pc_if = 64'h0;
      upd_valid = 1'b0; upd_pc = 64'h0; upd_taken = 1'b0; upd_target = 64'h0;
      upd_pred_taken = 1'b0; upd_pred_target = 64'h0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      look(64'h100, 1'b0, 64'h104, "reset_lookup");
      stats(4'd0, 4'd0, "reset_stats");

      // First allocation; the predictor said not-taken, so this mispredicts.
      upd(64'h100, 1'b1, 64'h200, 1'b0, 64'h104);
      #1;
      chk("alloc_mispredict", {63'd0, mispredict}, 64'd1);
      chk("alloc_redirect", redirect_pc, 64'h200);
      tick();
      upd_valid = 1'b0;
      look(64'h100, 1'b1, 64'h200, "alloc_hit");
      stats(4'd1, 4'd1, "alloc_stats");

      // Counter saturation: 2 -> 3, 3, 3, then 2, 1
      for (int i = 0; i < 3; i++) begin
         upd(64'h100, 1'b1, 64'h200, 1'b1, 64'h200);
         #1;
         chk("correct_no_mispredict", {63'd0, mispredict}, 64'd0);
         tick();
         upd_valid = 1'b0;
         look(64'h100, 1'b1, 64'h200, "sat_up");
      end
      upd(64'h100, 1'b0, 64'h999, 1'b1, 64'h200);
      #1;
      chk("nt_mispredict", {63'd0, mispredict}, 64'd1);
      chk("nt_redirect", redirect_pc, 64'h104);
      tick();
      upd_valid = 1'b0;
      look(64'h100, 1'b1, 64'h200, "dec_to_2");
      upd(64'h100, 1'b0, 64'h999, 1'b1, 64'h200);
      tick();
      upd_valid = 1'b0;
      look(64'h100, 1'b0, 64'h104, "dec_to_1");
      stats(4'd6, 4'd3, "sat_stats");

      // Taken hit with a new target: counter 1 -> 2, target overwritten.
      upd(64'h100, 1'b1, 64'h280, 1'b0, 64'h104);
      tick();
      upd_valid = 1'b0;
      look(64'h100, 1'b1, 64'h280, "retarget");

      // A wrong target on a correctly taken prediction still mispredicts.
      upd(64'h100, 1'b1, 64'h280, 1'b1, 64'h200);
      upd_valid = 1'b1;
      #1;
      chk("wrong_target_mispredict", {63'd0, mispredict}, 64'd1);
      upd_valid = 1'b0;
      #1;
      chk("idle_no_mispredict", {63'd0, mispredict}, 64'd0);
      stats(4'd7, 4'd4, "retarget_stats");

      // Aliasing: 0x140 shares index 0 with 0x100 but has a different tag.
      upd(64'h140, 1'b1, 64'h400, 1'b0, 64'h144);
      tick();
      upd_valid = 1'b0;
      look(64'h100, 1'b0, 64'h104, "alias_old_miss");
      look(64'h140, 1'b1, 64'h400, "alias_new_hit");

      // Same-cycle update and lookup of 0x300: the lookup sees old contents.
      upd(64'h300, 1'b1, 64'h500, 1'b0, 64'h304);
      look(64'h300, 1'b0, 64'h304, "same_cycle_old");
      tick();
      upd_valid = 1'b0;
      look(64'h300, 1'b1, 64'h500, "same_cycle_next");
      stats(4'd9, 4'd6, "alias_stats");

      // enable=0: no allocation and no stat change, but mispredict stays live.
      enable = 1'b0;
      upd(64'h180, 1'b1, 64'h600, 1'b0, 64'h184);
      #1;
      chk("dis_mispredict", {63'd0, mispredict}, 64'd1);
      chk("dis_redirect", redirect_pc, 64'h600);
      tick();
      upd_valid = 1'b0;
      enable = 1'b1;
      look(64'h180, 1'b0, 64'h184, "dis_no_alloc");
      look(64'h300, 1'b1, 64'h500, "dis_keep");
      stats(4'd9, 4'd6, "dis_stats");

      // Second set (index 1), then a one-cycle reset that empties everything.
      upd(64'h104, 1'b1, 64'h700, 1'b0, 64'h108);
      tick();
      upd_valid = 1'b0;
      look(64'h104, 1'b1, 64'h700, "idx1_hit");
      stats(4'd10, 4'd7, "pre_rst_stats");
      rst = 1'b1;
      upd(64'h100, 1'b1, 64'h200, 1'b0, 64'h104);
      tick();
      rst = 1'b0;
      upd_valid = 1'b0;
      look(64'h300, 1'b0, 64'h304, "rst_miss_300");
      look(64'h104, 1'b0, 64'h108, "rst_miss_104");
      look(64'h100, 1'b0, 64'h104, "rst_miss_100");
      stats(4'd0, 4'd0, "rst_stats");

      // pc_if+4 wraps modulo 2^64.
      look(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, "wrap");

      // Branch counter saturation with correctly predicted not-taken branches.
      upd(64'h800, 1'b0, 64'h0, 1'b0, 64'h804);
      for (int i = 0; i < 14; i++) tick();
      stats(4'd14, 4'd0, "stat_14");
      tick();
      stats(4'd15, 4'd0, "stat_15");
      tick();
      upd_valid = 1'b0;
      stats(4'd15, 4'd0, "stat_hold");
      look(64'h800, 1'b0, 64'h804, "nt_miss_no_alloc");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
